// File: rtl/mem_stage.sv
// mem_stage: RV32I memory stage, word loads/stores over a valid/ready dmem port with decoupled response.
// Latency: non-memory ops and ready stores reach wb_* one cycle later; loads take at least 2 cycles (request, response).
// Backpressure: stall holds the upstream pipeline while a request waits for ready or a load waits for data; HALT stalls forever.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   ex_to_mem             EX->MEM pipeline register (held stable by upstream while stall = 1)
//   dmem_req_*            request channel (valid/ready), word-aligned address
//   dmem_rsp_*            load response (valid only, always accepted)
//   stall                 hold IF/DE/EX and ex_to_mem this cycle
//   bp_mem                MEM bypass (alu_result; meaningless for loads)
//   wb_*                  registered MEM->WB outputs
//   bus_err               sticky timeout / misalignment flag
//
// Optional build macro: MEM_ALIGN_CHECK_EN (misaligned access -> bus_err + HALT instead of truncation).

package mem_stage_pkg;
   typedef struct packed {
      logic        mem_write;
      logic        mem_read;
      logic        reg_write;
      logic        instr_done;
      logic        is_final;
      logic [4:0]  rd;
      logic [31:0] mem_data;
      logic [31:0] alu_result;
   } ex_to_mem_s;
endpackage

module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  ex_to_mem_s  ex_to_mem,
   output logic        dmem_req_valid,
   input  logic        dmem_req_ready,
   output logic        dmem_req_we,
   output logic [31:0] dmem_req_addr,
   output logic [31:0] dmem_req_wdata,
   input  logic        dmem_rsp_valid,
   input  logic [31:0] dmem_rsp_rdata,
   output logic        stall,
   output logic [31:0] bp_mem,
   output logic        wb_reg_write,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        wb_instr_done,
   output logic        wb_is_final,
   output logic        bus_err
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, WAIT_RSP, HALT} state_t;

   state_t        r_state;
   logic [CW-1:0] r_tmo_cnt;
   logic          r_bus_err;
   logic          r_wb_reg_write;
   logic [4:0]    r_wb_rd;
   logic [31:0]   r_wb_data;
   logic          r_wb_instr_done;
   logic          r_wb_is_final;

   logic w_store;
   logic w_load;
   logic w_access;
   logic w_misalign;
   logic w_req_valid;
   logic w_stall;
   logic w_done;
   logic w_timeout;

   // A store takes precedence when both mem_write and a qualified load are set.
   assign w_store  = ex_to_mem.mem_write;
   assign w_load   = ex_to_mem.mem_read && ex_to_mem.reg_write && !ex_to_mem.mem_write;
   assign w_access = w_store || w_load;

`ifdef MEM_ALIGN_CHECK_EN
   assign w_misalign = w_access && (ex_to_mem.alu_result[1:0] != 2'b00);
`else
   assign w_misalign = 1'b0;
`endif

   always_comb begin
      w_req_valid = 1'b0;
      w_stall     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_access) begin
               if (w_misalign) begin
                  w_stall = 1'b1;
               end else begin
                  w_req_valid = 1'b1;
                  w_done      = w_store && dmem_req_ready;
                  w_stall     = !w_done;
               end
            end
         end
         WAIT_RSP: begin
            w_done  = dmem_rsp_valid;
            w_stall = !dmem_rsp_valid;
         end
         HALT:    w_stall = 1'b1;
         default: w_stall = 1'b0;
      endcase
   end

   // Fires on the TIMEOUT-th stalled cycle of one access; r_tmo_cnt holds the stalls already seen.
   assign w_timeout = (TIMEOUT != 0) && w_stall && (r_state != HALT)
                      && (r_tmo_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state         <= IDLE;
         r_tmo_cnt       <= '0;
         r_bus_err       <= 1'b0;
         r_wb_reg_write  <= 1'b0;
         r_wb_rd         <= '0;
         r_wb_data       <= '0;
         r_wb_instr_done <= 1'b0;
         r_wb_is_final   <= 1'b0;
      end else begin
         // Bubble unless an instruction completes below.
         r_wb_reg_write  <= 1'b0;
         r_wb_instr_done <= 1'b0;
         r_wb_is_final   <= 1'b0;

         case (r_state)
            IDLE: begin
               if (w_misalign) begin
                  r_bus_err <= 1'b1;
                  r_state   <= HALT;
               end else if (!w_access || w_done) begin
                  r_wb_reg_write  <= ex_to_mem.reg_write && !w_access;
                  r_wb_rd         <= ex_to_mem.rd;
                  r_wb_data       <= ex_to_mem.alu_result;
                  r_wb_instr_done <= ex_to_mem.instr_done;
                  r_wb_is_final   <= ex_to_mem.is_final;
               end else if (w_load && dmem_req_ready) begin
                  r_state <= WAIT_RSP;
               end
            end
            WAIT_RSP: begin
               if (dmem_rsp_valid) begin
                  r_wb_reg_write  <= 1'b1;
                  r_wb_rd         <= ex_to_mem.rd;
                  r_wb_data       <= dmem_rsp_rdata;
                  r_wb_instr_done <= ex_to_mem.instr_done;
                  r_wb_is_final   <= ex_to_mem.is_final;
                  r_state         <= IDLE;
               end
            end
            default: r_state <= HALT;
         endcase

         if (w_done) begin
            r_tmo_cnt <= '0;
         end else if (w_stall && (r_state != HALT) && (r_tmo_cnt != '1)) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
         end

         if (w_timeout) begin
            r_bus_err <= 1'b1;
            r_state   <= HALT;
         end
      end
   end

   assign dmem_req_valid = rst_n && w_req_valid;
   assign stall          = rst_n && w_stall;
   assign dmem_req_we    = w_store;
   assign dmem_req_addr  = {ex_to_mem.alu_result[31:2], 2'b00};
   assign dmem_req_wdata = ex_to_mem.mem_data;
   assign bp_mem         = ex_to_mem.alu_result;
   assign wb_reg_write   = r_wb_reg_write;
   assign wb_rd          = r_wb_rd;
   assign wb_data        = r_wb_data;
   assign wb_instr_done  = r_wb_instr_done;
   assign wb_is_final    = r_wb_is_final;
   assign bus_err        = r_bus_err;

endmodule
